vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock.
- Produces pixel coordinates (x, y), the active-video flag, sync pulses and line/frame strobes.
- Sits directly upstream of the screen renderers (win screen, game field, title), which decode x/y combinationally into vga_color in the same cycle.
- Frame strobe lets game logic update state between frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..16
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  out  1  horizontal sync at SYNC_ACTIVE level during the sync region
- vsync  out  1  vertical sync at SYNC_ACTIVE level during the sync region
- pix_en  out  1  one-clk pulse on the last clk of each pixel period
- line_start  out  1  pix_en && x==0
- frame_start  out  1  pix_en && x==0 && y==0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be <=1024; elaboration fails otherwise.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div==CLK_DIV-1) && !rst.
  - With CLK_DIV=1, pix_en is high every non-reset cycle.
- Horizontal counter:
  - h advances only when pix_en is high.
  - h==H_TOTAL-1 wraps to 0; otherwise h+1.
- Vertical counter:
  - v advances only when pix_en is high and h wraps.
  - v==V_TOTAL-1 wraps to 0.
- x and y are the h/v registers driven directly, with no extra pipeline stage.
- active, hsync and vsync are registered:
  - Computed from the next h/v values, so they are cycle-aligned with x/y (zero relative latency).
  - hsync asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - vsync changes only together with an h wrap, i.e. on a line boundary.
- Strobes:
  - line_start and frame_start are decoded from registered state AND pix_en.
  - Each is exactly one clk wide, asserted on the last clk of pixel (0,y) / (0,0).
- Each (x,y) pair is held for exactly CLK_DIV clk cycles.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clk cycles (840,000 at defaults).
- Reset values:
  - div=0, x=0, y=0, active=1.
  - hsync=vsync=!SYNC_ACTIVE (1 at default), pix_en=0, line_start=0, frame_start=0.
- First pix_en occurs CLK_DIV-1 cycles after the first cycle with rst low; first frame_start coincides with it.
- Reset mid-frame: on the next clk edge all state returns to reset values, no partial sync pulse is held, and the raster restarts at (0,0).
- rst held: outputs stay at reset values indefinitely.
- Simultaneous h and v wrap: x=0, y=0 and vsync deasserted all appear on the same edge.

Decomposition:
- Shared package vga_pkg holds:
  - The 640x480 timing constants (defaults above), H_TOTAL and V_TOTAL.
  - SCREEN_W/SCREEN_H.
  - The palette constants shared by renderers (COLOR_BG, COLOR_FG, etc.).
- One sub-module, mod_counter (parameterised modulus and width, with enable, wrap output and sync reset), used three times: divider, h and v.

Test Plan:
- Reset: hold rst 5 cycles -> x=0, y=0, active=1, hsync=1, vsync=1, pix_en=0; release rst -> pix_en first high 1 cycle later (CLK_DIV=2), frame_start high in that same cycle.
- Pixel cadence: run 20 clk -> pix_en toggles every 2nd clk; x increments 0..9, each value held exactly 2 clk.
- Line timing, one line:
  - active falls at x=640.
  - hsync low for exactly x=656..751 (96 pixels, 192 clk).
  - x wraps 799->0 with y 0->1 and line_start high once.
- Frame timing:
  - vsync low for exactly y=490..491.
  - y wraps 524->0 with frame_start pulse.
  - Frame-to-frame frame_start spacing = 840,000 clk.
  - 307,200 pix_en cycles with active=1 per frame.
- Reset mid-frame: assert rst at x=700, y=300 for 1 cycle -> next edge x=0, y=0, hsync/vsync deasserted; next frame_start 1 cycle after release.
- CLK_DIV=1 build: pix_en constant high after reset; frame period 420,000 clk; hsync width 96 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 raster timing constants, screen geometry,
// coordinate/colour types and the palette used by the screen renderers.
package vga_pkg;

  // Horizontal timing, in pixels
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 50 MHz system clock divided down to the 25 MHz pixel rate
  localparam int unsigned VGA_CLK_DIV     = 2;
  // Sync pulses are active-low in the standard 640x480 mode
  localparam bit          VGA_SYNC_ACTIVE = 1'b0;

  // Visible area as seen by the renderers
  localparam int unsigned SCREEN_W = VGA_H_ACTIVE;
  localparam int unsigned SCREEN_H = VGA_V_ACTIVE;

  // Coordinates are 10 bits; bounds carry one extra bit so that a
  // boundary equal to 1024 still compares correctly.
  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   bound_t;

  // 12-bit RGB444 colour shared by all renderers
  typedef logic [11:0] color_t;
  localparam color_t COLOR_BG     = 12'h000;
  localparam color_t COLOR_FG     = 12'hFFF;
  localparam color_t COLOR_ACCENT = 12'h0AF;
  localparam color_t COLOR_WARN   = 12'hF80;
  localparam color_t COLOR_WIN    = 12'h0F0;
  localparam color_t COLOR_BORDER = 12'h444;

  // True when lo <= pos < hi
  function automatic logic inWindow(input bound_t pos, input bound_t lo, input bound_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD up-counter with enable, synchronous active-high
// reset, a wrap strobe on the enabled terminal count, and a look-ahead of
// the value the counter will hold after the next clock edge.
module mod_counter #(
  parameter int unsigned MOD   = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  if ((MOD < 1) || (MOD > (1 << WIDTH))) begin : gCheckMod
    $error("mod_counter: MOD does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold when disabled, otherwise increment and wrap at MOD-1
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = rst_i ? '0 : count_d;
  assign wrap_o  = en_i && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing. A clock divider produces the pixel
// enable, which steps a horizontal counter, whose wrap steps a vertical
// counter. Sync and active flags are registered from the look-ahead counts
// so they line up with x/y on the same cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter bit          SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam bound_t H_ACTIVE_B   = bound_t'(H_ACTIVE);
  localparam bound_t H_SYNC_BEG_B = bound_t'(H_ACTIVE + H_FP);
  localparam bound_t H_SYNC_END_B = bound_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam bound_t V_ACTIVE_B   = bound_t'(V_ACTIVE);
  localparam bound_t V_SYNC_BEG_B = bound_t'(V_ACTIVE + V_FP);
  localparam bound_t V_SYNC_END_B = bound_t'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024) begin : gCheckH
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : gCheckV
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : gCheckDiv
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end

  logic [DIV_W-1:0] divCount;
  logic [DIV_W-1:0] divNext;
  logic             divWrap;
  coord_t           hCount;
  coord_t           hNext;
  logic             hWrap;
  coord_t           vCount;
  coord_t           vNext;
  logic             vWrap;
  logic             unusedBits;

  logic active_q, active_d;
  logic hsync_q,  hsync_d;
  logic vsync_q,  vsync_d;

  // Pixel-rate divider: free-running, its wrap marks the last clk of a pixel
  mod_counter #(.MOD(CLK_DIV), .WIDTH(DIV_W)) uDiv (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (1'b1),
    .count_o (divCount),
    .next_o  (divNext),
    .wrap_o  (divWrap)
  );

  assign pix_en = divWrap && !rst;

  // Horizontal position, stepped once per pixel
  mod_counter #(.MOD(H_TOTAL), .WIDTH(COORD_W)) uH (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (pix_en),
    .count_o (hCount),
    .next_o  (hNext),
    .wrap_o  (hWrap)
  );

  // Vertical position, stepped when a line ends
  mod_counter #(.MOD(V_TOTAL), .WIDTH(COORD_W)) uV (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (hWrap),
    .count_o (vCount),
    .next_o  (vNext),
    .wrap_o  (vWrap)
  );

  assign unusedBits = ^{divCount, divNext, vWrap};

  // Decode the position the counters are about to take, so the registered
  // flags change on the same edge as x/y
  always_comb begin
    active_d = 1'b1;
    hsync_d  = !SYNC_ACTIVE;
    vsync_d  = !SYNC_ACTIVE;
    active_d = inWindow(bound_t'(hNext), '0, H_ACTIVE_B) &&
               inWindow(bound_t'(vNext), '0, V_ACTIVE_B);
    if (inWindow(bound_t'(hNext), H_SYNC_BEG_B, H_SYNC_END_B)) begin
      hsync_d = SYNC_ACTIVE;
    end
    if (inWindow(bound_t'(vNext), V_SYNC_BEG_B, V_SYNC_END_B)) begin
      vsync_d = SYNC_ACTIVE;
    end
  end

  // Registered active/sync flags; reset drops any sync pulse in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b1;
      hsync_q  <= !SYNC_ACTIVE;
      vsync_q  <= !SYNC_ACTIVE;
    end else begin
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign x           = hCount;
  assign y           = vCount;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = pix_en && (hCount == '0);
  assign frame_start = line_start && (vCount == '0);

endmodule
